// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and line-memory width defaults
package mem_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way round-robin select; on contention the requester other than last_i wins
module mem_arb_pick (
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic any_o,
  output logic choice_o
);
  assign any_o    = v0_i | v1_i;
  assign choice_o = (v0_i & v1_i) ? ~last_i : v1_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one line-memory port between icache (r0) and dcache (r1); MEM_ARB_PERF_EN adds grant/wait counters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_wmask,
  input  logic [LINE_W-1:0] r0_wdata,
  output logic [LINE_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_wmask,
  input  logic [LINE_W-1:0] r1_wdata,
  output logic [LINE_W-1:0] r1_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wmask,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_wait
`endif
);
  state_t              state_q;
  logic                last_q, gnt_q;
  logic                mem_valid_q, mem_wmask_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic                r0_ready_q, r1_ready_q;
  logic [LINE_W-1:0]   r0_rdata_q, r1_rdata_q;
  logic                any, choice;

  mem_arb_pick u_pick (
    .v0_i    (r0_valid),
    .v1_i    (r1_valid),
    .last_i  (last_q),
    .any_o   (any),
    .choice_o(choice)
  );

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

  // Grant/forward/respond FSM; requester inputs are only sampled on the IDLE grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wmask_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (any) begin
          gnt_q       <= choice;
          last_q      <= choice;
          mem_valid_q <= 1'b1;
          mem_addr_q  <= choice ? r1_addr : r0_addr;
          mem_wmask_q <= choice ? r1_wmask : r0_wmask;
          mem_wdata_q <= choice ? r1_wdata : r0_wdata;
          state_q     <= S_BUSY;
        end
        S_BUSY: if (mem_ready) begin
          mem_valid_q <= 1'b0;
          if (gnt_q) begin
            r1_rdata_q <= mem_rdata;
            r1_ready_q <= 1'b1;
          end else begin
            r0_rdata_q <= mem_rdata;
            r0_ready_q <= 1'b1;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          r0_ready_q <= 1'b0;
          r1_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic        wait0, wait1;
  logic [31:0] perf_grant0_q, perf_grant1_q, perf_wait_q;

  assign wait0 = r0_valid & ~((state_q == S_IDLE) ? (any & ~choice) : ~gnt_q);
  assign wait1 = r1_valid & ~((state_q == S_IDLE) ? (any & choice) : gnt_q);
  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_wait   = perf_wait_q;

  // Free-running wrap-around counters: grants per requester and cycles with a pending, unserved request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_wait_q   <= '0;
    end else begin
      if (state_q == S_IDLE && any && !choice) perf_grant0_q <= perf_grant0_q + 32'd1;
      if (state_q == S_IDLE && any && choice) perf_grant1_q <= perf_grant1_q + 32'd1;
      if (wait0 | wait1) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end
`endif
endmodule
